// File: rtl/video_timing_pkg.sv
// Shared timing constants and types for the video timing generator.
// Defaults describe 640x480@60 with negative sync polarity.
package video_timing_pkg;

  // 640x480@60 horizontal timing, in pixels
  localparam int unsigned DefHAddr  = 640;
  localparam int unsigned DefHFront = 16;
  localparam int unsigned DefHSync  = 96;
  localparam int unsigned DefHBack  = 48;

  // 640x480@60 vertical timing, in lines
  localparam int unsigned DefVAddr  = 480;
  localparam int unsigned DefVFront = 10;
  localparam int unsigned DefVSync  = 2;
  localparam int unsigned DefVBack  = 33;

  localparam bit SyncActiveLow  = 1'b0;
  localparam bit SyncActiveHigh = 1'b1;

  localparam int unsigned DefCw = 10;

  function automatic int unsigned timing_total(input int unsigned addr, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
    return addr + front + sync + back;
  endfunction

  localparam int unsigned DefHTotal = timing_total(DefHAddr, DefHFront, DefHSync, DefHBack);
  localparam int unsigned DefVTotal = timing_total(DefVAddr, DefVFront, DefVSync, DefVBack);

  // Single-bit outputs that are registered together so they stay aligned with hpos/vpos.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
    logic line_start;
    logic frame_start;
    logic vblank_pending;
  } vtg_flags_t;

  function automatic vtg_flags_t vtg_reset_flags(input bit hsync_pol, input bit vsync_pol);
    vtg_flags_t f;
    f.hsync          = ~hsync_pol;
    f.vsync          = ~vsync_pol;
    f.display_on     = 1'b1;
    f.line_start     = 1'b0;
    f.frame_start    = 1'b0;
    f.vblank_pending = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled modulo counter: counts 0..Terminal, flags the wrap and exposes its next value
// so the owner can register decoded outputs in step with the count.
module wrap_counter #(
  parameter int unsigned Width    = 10,
  parameter int unsigned Terminal = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count,
  output logic [Width-1:0] count_next,
  output logic             wrap
);

  if (64'(Terminal) >= (64'd1 << Width)) begin : gen_bad_terminal
    $error("wrap_counter: Terminal does not fit in Width bits");
  end

  localparam logic [Width-1:0] TermVal = Width'(Terminal);

  logic [Width-1:0] count_q;

  assign wrap = en && (count_q == TermVal);

  always_comb begin
    count_next = count_q;
    if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line position, syncs, blanking and frame markers.
// Optional 16-bit frame counter enabled by defining VTG_FRAMECNT_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ADDR    = DefHAddr,
  parameter int unsigned H_FRONT   = DefHFront,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BACK    = DefHBack,
  parameter int unsigned V_ADDR    = DefVAddr,
  parameter int unsigned V_FRONT   = DefVFront,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BACK    = DefVBack,
  parameter bit          HSYNC_POL = SyncActiveLow,
  parameter bit          VSYNC_POL = SyncActiveLow,
  parameter int unsigned CW        = DefCw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          vblank_ack,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_pending
`ifdef VTG_FRAMECNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned HTotal = timing_total(H_ADDR, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = timing_total(V_ADDR, V_FRONT, V_SYNC, V_BACK);
  localparam longint unsigned CountRange = 64'd1 << CW;

  if (64'(HTotal) > CountRange || 64'(VTotal) > CountRange) begin : gen_bad_total
    $error("video_timing_gen: H or V total exceeds 2**CW");
  end
  if (H_ADDR == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ADDR == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : gen_bad_field
    $error("video_timing_gen: every timing field must be non-zero");
  end

  localparam logic [CW-1:0] HAddrC     = CW'(H_ADDR);
  localparam logic [CW-1:0] HSyncFirst = CW'(H_ADDR + H_FRONT);
  localparam logic [CW-1:0] HSyncLast  = CW'(H_ADDR + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VAddrC     = CW'(V_ADDR);
  localparam logic [CW-1:0] VSyncFirst = CW'(V_ADDR + V_FRONT);
  localparam logic [CW-1:0] VSyncLast  = CW'(V_ADDR + V_FRONT + V_SYNC - 1);

  localparam vtg_flags_t ResetFlags = vtg_reset_flags(HSYNC_POL, VSYNC_POL);

  logic [CW-1:0] hpos_next, vpos_next;
  logic          h_wrap, v_wrap;

  wrap_counter #(
    .Width    (CW),
    .Terminal (HTotal - 1)
  ) u_hcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ce),
    .count      (hpos),
    .count_next (hpos_next),
    .wrap       (h_wrap)
  );

  // h_wrap already carries ce, so the line counter only steps on a qualified wrap.
  wrap_counter #(
    .Width    (CW),
    .Terminal (VTotal - 1)
  ) u_vcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (h_wrap),
    .count      (vpos),
    .count_next (vpos_next),
    .wrap       (v_wrap)
  );

  vtg_flags_t flags_d, flags_q;
  logic       vblank_set;

  // Decoding from the counters' next values lets the registered flags land in the same
  // cycle as the position they describe.
  assign vblank_set = h_wrap && (vpos_next == VAddrC);

  always_comb begin
    flags_d = flags_q;
    flags_d.hsync = (hpos_next >= HSyncFirst && hpos_next <= HSyncLast) ? HSYNC_POL
                                                                        : ~HSYNC_POL;
    flags_d.vsync = (vpos_next >= VSyncFirst && vpos_next <= VSyncLast) ? VSYNC_POL
                                                                        : ~VSYNC_POL;
    flags_d.display_on     = (hpos_next < HAddrC) && (vpos_next < VAddrC);
    flags_d.line_start     = h_wrap;
    flags_d.frame_start    = v_wrap;
    // A set coinciding with an ack wins.
    flags_d.vblank_pending = vblank_set | (flags_q.vblank_pending & ~vblank_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= ResetFlags;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign hsync          = flags_q.hsync;
  assign vsync          = flags_q.vsync;
  assign display_on     = flags_q.display_on;
  assign line_start     = flags_q.line_start;
  assign frame_start    = flags_q.frame_start;
  assign vblank_pending = flags_q.vblank_pending;

`ifdef VTG_FRAMECNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ADDR, 640, addressable pixels per line; H_FRONT, 16, front porch; H_SYNC, 96, hsync width; H_BACK, 48, back porch.
REQ-002 Parameter V_ADDR, 480, addressable lines; V_FRONT, 10; V_SYNC, 2; V_BACK, 33 (all in lines).
REQ-003 Parameter HSYNC_POL, 0, active level of hsync; VSYNC_POL, 0, active level of vsync.
REQ-004 Parameter CW, 10, width of position counters.
REQ-005 Port clk  input  1  pixel clock, rising edge.
REQ-006 Port rst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-007 Port ce  input  1  pixel enable; counters advance only on clk edges with ce=1.
REQ-008 Port vblank_ack  input  1  clears vblank_pending.
REQ-009 Port hpos, vpos  output  CW each  current pixel position; (0,0) = first addressable pixel.
REQ-010 Port hsync, vsync  output  1 each  sync outputs at configured polarity.
REQ-011 Port display_on  output  1  high iff hpos<H_ADDR and vpos<V_ADDR.
REQ-012 Port line_start, frame_start  output  1 each  single-clk pulses.
REQ-013 Port vblank_pending  output  1  sticky vertical-blank flag.
REQ-014 Port frame_cnt  output  16  frame counter (present only with VTG_FRAMECNT_EN).

Function
REQ-015 H_TOTAL=H_ADDR+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise; elaboration SHALL fail if either exceeds 2^CW or any field is 0.
REQ-016 On ce=1: hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments; vpos wraps to 0 after V_TOTAL-1 only on that hpos wrap.
REQ-017 ce=0: all position-derived outputs hold; pulses deassert.
REQ-018 All outputs registered and mutually aligned: hsync active exactly while hpos in [H_ADDR+H_FRONT, H_ADDR+H_FRONT+H_SYNC-1]; vsync active exactly while vpos in [V_ADDR+V_FRONT, V_ADDR+V_FRONT+V_SYNC-1]; no one-cycle lag vs. hpos/vpos.
REQ-019 display_on decoded from next-state positions, so it matches REQ-011 in every cycle.
REQ-020 line_start high for one clk in the cycle hpos first reads 0 after a wrap; frame_start high in the cycle (hpos,vpos) first reads (0,0) after a wrap; frame_start implies line_start.
REQ-021 vblank_pending set in the cycle vpos first reads V_ADDR; cleared on clk with vblank_ack=1; set and ack in the same cycle -> stays set.
REQ-022 No combinational path from any input to any output.

Reset
REQ-023 rst_n=0 asynchronously forces hpos=0, vpos=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, display_on=1, line_start=0, frame_start=0, vblank_pending=0, frame_cnt=0.
REQ-024 Reset release mid-frame restarts at (0,0) with no frame_start pulse for that first frame.

Configuration
REQ-025 Macro VTG_FRAMECNT_EN defined: frame_cnt increments (mod 2^16) in the frame_start cycle.
REQ-026 Macro undefined: frame_cnt port and its register are absent; all other behaviour unchanged.

Structure
REQ-027 Package video_timing_pkg SHALL hold 640x480@60 default timing constants, polarity constants, and a localparam helper for H_TOTAL/V_TOTAL.
REQ-028 One sub-module wrap_counter (parametrised width and terminal count, enable in, wrap pulse out), instantiated for H and V.

Verification
REQ-029 Defaults, ce=1, reset release -> after 800 clks hpos=0, vpos=1, line_start pulses once; after 420000 clks one frame_start, frame_cnt=1 (macro on).
REQ-030 Defaults -> hsync=0 exactly for hpos 656..751; vsync=0 exactly for vpos 490..491; display_on=0 at hpos=640 and at vpos=480.
REQ-031 ce toggled 1-of-3 -> all position outputs hold during ce=0; full frame takes 1260000 clks.
REQ-032 vblank_ack asserted in the same cycle vpos reaches 480 -> vblank_pending=1; ack next cycle -> 0.
REQ-033 rst_n pulsed low asynchronously mid-line at hpos=300, vpos=200 -> outputs at reset values immediately, no frame_start at restart.
REQ-034 Params H=8/2/2/4, V=4/1/1/2, CW=5, POL=1 -> hsync=1 for hpos 10..11, V_TOTAL=8 lines, counters wrap correctly.
